// File: rtl/trap_unit.sv
// Machine-mode trap responder and CSR file: accepts WB trap packets, redirects fetch one
// cycle later, and services Zicsr reads/writes including the 64-bit mcycle/minstret counters.
package trap_pkg;
   typedef enum logic {TRAP_ENTER = 1'b0, TRAP_RETURN = 1'b1} trap_mode_e;

   typedef struct packed {
      logic        valid;
      trap_mode_e  mode;
      logic [31:0] cause;
      logic [31:0] pc;
      logic [31:0] tval;
   } trap_req_t;

   typedef struct packed {
      logic        redirflag;
      logic [31:0] redirpc;
   } trap_res_t;
endpackage

module trap_unit
   import trap_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
   parameter logic [31:0] HARTID      = 32'd0
) (
   input  logic        clk,
   input  logic        start,
   input  trap_req_t   trap_req_w,
   input  logic        retire_w,
   input  logic        csr_valid_w,
   input  logic [2:0]  csr_funct3_w,
   input  logic [11:0] csr_addr_w,
   input  logic [31:0] csr_wdata_w,
   input  logic        csr_srczero_w,
   output logic [31:0] csr_rdata_w,
   output logic        csr_illegal_w,
   output trap_res_t   trap_res
);
   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   typedef enum logic {IDLE, REDIRECT} state_e;
   state_e state, state_next;

   logic        mie, mpie;
   logic [31:0] mtvec, mepc, mcause, mtval, mscratch, redirpc;
   logic [63:0] mcycle, minstret;

   logic        known, read_only, wants_write, accept, wen;
   logic [31:0] wval;
   logic        unused_imm;

   // The immediate form only changes how WB builds csr_wdata_w.
   assign unused_imm = csr_funct3_w[2];

   always_comb begin
      csr_rdata_w = '0;
      known       = 1'b1;
      case (csr_addr_w)
         A_MSTATUS:   csr_rdata_w = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
         A_MTVEC:     csr_rdata_w = mtvec;
         A_MSCRATCH:  csr_rdata_w = mscratch;
         A_MEPC:      csr_rdata_w = mepc;
         A_MCAUSE:    csr_rdata_w = mcause;
         A_MTVAL:     csr_rdata_w = mtval;
         A_MCYCLE:    csr_rdata_w = mcycle[31:0];
         A_MCYCLEH:   csr_rdata_w = mcycle[63:32];
         A_MINSTRET:  csr_rdata_w = minstret[31:0];
         A_MINSTRETH: csr_rdata_w = minstret[63:32];
         A_MVENDORID: csr_rdata_w = '0;
         A_MHARTID:   csr_rdata_w = HARTID;
         default:     known = 1'b0;
      endcase
   end

   assign read_only     = (csr_addr_w[11:10] == 2'b11);
   assign wants_write   = (csr_funct3_w[1:0] == 2'b01) ||
                          ((csr_funct3_w[1:0] != 2'b00) && !csr_srczero_w);
   assign csr_illegal_w = csr_valid_w && (!known || (read_only && wants_write));
   assign accept        = (state == IDLE) && trap_req_w.valid;
   assign wen           = csr_valid_w && wants_write && !csr_illegal_w && !accept;

   always_comb begin
      case (csr_funct3_w[1:0])
         2'b01:   wval = csr_wdata_w;
         2'b10:   wval = csr_rdata_w | csr_wdata_w;
         2'b11:   wval = csr_rdata_w & ~csr_wdata_w;
         default: wval = csr_rdata_w;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!start) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      if (state == IDLE && trap_req_w.valid) state_next = REDIRECT;
   end

   always_ff @(posedge clk) begin
      if (!start) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= RESET_MTVEC & ~32'd3;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
         mscratch <= '0;
         redirpc  <= '0;
      end else if (accept) begin
         if (trap_req_w.mode == TRAP_ENTER) begin
            mepc    <= trap_req_w.pc & ~32'd3;
            mcause  <= trap_req_w.cause;
            mtval   <= trap_req_w.tval;
            mpie    <= mie;
            mie     <= 1'b0;
            redirpc <= mtvec;
         end else begin
            mie     <= mpie;
            mpie    <= 1'b1;
            redirpc <= mepc;
         end
      end else if (wen) begin
         case (csr_addr_w)
            A_MSTATUS:  begin mie <= wval[3]; mpie <= wval[7]; end
            A_MTVEC:    mtvec    <= {wval[31:2], 2'b00};
            A_MEPC:     mepc     <= {wval[31:2], 2'b00};
            A_MCAUSE:   mcause   <= wval;
            A_MTVAL:    mtval    <= wval;
            A_MSCRATCH: mscratch <= wval;
            default: ;
         endcase
      end
   end

   // A written half replaces that half and suppresses the increment for the whole counter.
   always_ff @(posedge clk) begin
      if (!start) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (wen && csr_addr_w == A_MCYCLE)       mcycle[31:0]  <= wval;
         else if (wen && csr_addr_w == A_MCYCLEH) mcycle[63:32] <= wval;
         else                                     mcycle        <= mcycle + 64'd1;

         if (wen && csr_addr_w == A_MINSTRET)       minstret[31:0]  <= wval;
         else if (wen && csr_addr_w == A_MINSTRETH) minstret[63:32] <= wval;
         else if (retire_w && !accept)              minstret        <= minstret + 64'd1;
      end
   end

   assign trap_res.redirflag = (state == REDIRECT);
   assign trap_res.redirpc   = redirpc;
endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: CSR vector table, hand-written trap/counter sequences,
// and a randomized run compared every cycle against a behavioural model.
module tb_trap_unit;
   import trap_pkg::*;

   logic        clk = 1'b0;
   logic        start;
   trap_req_t   req;
   logic        retire, csr_valid, sz;
   logic [2:0]  f3;
   logic [11:0] addr;
   logic [31:0] wd, rdata;
   logic        illegal;
   trap_res_t   res;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101;

   trap_unit #(.RESET_MTVEC(32'h0000_0100), .HARTID(32'd0)) dut (
      .clk(clk), .start(start), .trap_req_w(req), .retire_w(retire),
      .csr_valid_w(csr_valid), .csr_funct3_w(f3), .csr_addr_w(addr),
      .csr_wdata_w(wd), .csr_srczero_w(sz), .csr_rdata_w(rdata),
      .csr_illegal_w(illegal), .trap_res(res)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   bit          m_pend, m_mie, m_mpie;
   logic [31:0] m_redirpc, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
   logic [63:0] m_cyc, m_ins;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void m_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
      ok = 1;
      v  = 0;
      case (a)
         12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[31:0];
         12'hB82: v = m_ins[63:32];
         12'hF11: v = 0;
         12'hF14: v = 0;
         default: ok = 0;
      endcase
   endfunction

   function automatic bit m_writes();
      return (f3[1:0] == 2'b01) || (f3[1:0] != 2'b00 && !sz);
   endfunction

   function automatic bit m_illegal();
      logic [31:0] v;
      bit ok;
      m_read(addr, v, ok);
      return csr_valid && (!ok || (addr >= 12'hC00 && m_writes()));
   endfunction

   task automatic model_compare();
      logic [31:0] v;
      bit ok;
      m_read(addr, v, ok);
      chk("m_rdata", rdata, v);
      chk("m_illegal", 32'(illegal), 32'(m_illegal()));
      chk("m_redirflag", 32'(res.redirflag), 32'(m_pend));
      chk("m_redirpc", res.redirpc, m_redirpc);
   endtask

   task automatic model_update();
      logic [31:0] old, nv;
      bit ok, acc, do_w, cyc_w, ins_w;
      if (!start) begin
         m_pend = 0; m_mie = 0; m_mpie = 0;
         m_redirpc = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
         m_mtval = 0; m_mscratch = 0; m_cyc = 0; m_ins = 0;
         return;
      end
      acc  = !m_pend && req.valid;
      m_read(addr, old, ok);
      do_w = csr_valid && m_writes() && !m_illegal() && !acc;
      nv   = (f3[1:0] == 2'b01) ? wd : (f3[1:0] == 2'b10) ? (old | wd) : (old & ~wd);
      cyc_w = 0; ins_w = 0;
      if (do_w) begin
         case (addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = nv & ~32'd3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'd3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_w = 1; end
            12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cyc_w = 1; end
            12'hB02: begin m_ins = {m_ins[63:32], nv}; ins_w = 1; end
            12'hB82: begin m_ins = {nv, m_ins[31:0]}; ins_w = 1; end
            default: ;
         endcase
      end
      if (!cyc_w) m_cyc = m_cyc + 1;
      if (!ins_w && retire && !acc) m_ins = m_ins + 1;
      if (acc) begin
         if (req.mode == TRAP_ENTER) begin
            m_mepc = req.pc & ~32'd3; m_mcause = req.cause; m_mtval = req.tval;
            m_mpie = m_mie; m_mie = 0; m_redirpc = m_mtvec;
         end else begin
            m_mie = m_mpie; m_mpie = 1; m_redirpc = m_mepc;
         end
      end
      m_pend = acc;
   endtask

   task automatic tick();
      #1 model_compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_in();
      req = '0; retire = 0; csr_valid = 0; f3 = RS; addr = 12'h340; wd = 0; sz = 1;
   endtask

   task automatic csr_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d,
                         input logic z);
      csr_valid = 1; f3 = f; addr = a; wd = d; sz = z;
   endtask

   task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
      csr_op(RS, a, 0, 1);
      #1 chk(nm, rdata, exp);
      tick();
      clear_in();
   endtask

   task automatic do_reset();
      clear_in();
      start = 0;
      tick();
      tick();
      start = 1;
   endtask

   task automatic trap(input trap_mode_e md, input logic [31:0] c, input logic [31:0] p,
                       input logic [31:0] tv);
      req.valid = 1; req.mode = md; req.cause = c; req.pc = p; req.tval = tv;
   endtask

   typedef struct packed {
      logic [2:0]  f;
      logic [11:0] a;
      logic [31:0] d;
      logic        z;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t vt[$];

   initial begin
      vt = '{
         '{RW,  12'h340, 32'hA5A5_0001, 1'b0, 32'h0000_0000, 1'b0},
         '{RS,  12'h340, 32'h0000_00F0, 1'b0, 32'hA5A5_0001, 1'b0},
         '{RC,  12'h340, 32'hA500_0000, 1'b0, 32'hA5A5_00F1, 1'b0},
         '{RS,  12'h340, 32'hFFFF_FFFF, 1'b1, 32'h00A5_00F1, 1'b0},
         '{RWI, 12'h340, 32'h0000_0005, 1'b0, 32'h00A5_00F1, 1'b0},
         '{RS,  12'h340, 32'h0000_0000, 1'b1, 32'h0000_0005, 1'b0},
         '{RW,  12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1800, 1'b0},
         '{RS,  12'h300, 32'h0000_0000, 1'b1, 32'h0000_1888, 1'b0},
         '{RC,  12'h300, 32'h0000_0008, 1'b0, 32'h0000_1888, 1'b0},
         '{RS,  12'h300, 32'h0000_0000, 1'b1, 32'h0000_1880, 1'b0},
         '{RW,  12'h305, 32'hFFFF_FFFF, 1'b0, 32'h0000_0100, 1'b0},
         '{RS,  12'h305, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0},
         '{RW,  12'hF14, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1},
         '{RS,  12'hF14, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0},
         '{RS,  12'hF11, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1},
         '{RW,  12'h7C0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1},
         '{RW,  12'h341, 32'h0000_2003, 1'b0, 32'h0000_0000, 1'b0},
         '{RS,  12'h341, 32'h0000_0000, 1'b1, 32'h0000_2000, 1'b0},
         '{RW,  12'h342, 32'h8000_000B, 1'b0, 32'h0000_0000, 1'b0},
         '{RS,  12'h342, 32'h0000_0000, 1'b1, 32'h8000_000B, 1'b0},
         '{RW,  12'h343, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0},
         '{RS,  12'h343, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0}
      };

      clear_in();
      start = 0;
      @(negedge clk);

      // Reset state
      do_reset();
      #1 chk("rst_redirflag", 32'(res.redirflag), 32'd0);
      rd_chk("rst_mcycle", 12'hB00, 32'd0);
      rd_chk("rst_mstatus", 12'h300, 32'h1800);
      rd_chk("rst_mtvec", 12'h305, 32'h100);
      rd_chk("rst_mepc", 12'h341, 32'h0);

      // CSR vector table
      foreach (vt[i]) begin
         csr_op(vt[i].f, vt[i].a, vt[i].d, vt[i].z);
         #1;
         chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
         chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vt[i].exp_ill));
         tick();
         clear_in();
      end

      // Trap entry with MIE=1
      do_reset();
      csr_op(RW, 12'h300, 32'h8, 0);
      tick();
      clear_in();
      trap(TRAP_ENTER, 32'd2, 32'h1234_5678, 32'hDEAD_BEEF);
      tick();
      clear_in();
      #1 chk("enter_redirflag", 32'(res.redirflag), 32'd1);
      chk("enter_redirpc", res.redirpc, 32'h100);
      rd_chk("enter_mepc", 12'h341, 32'h1234_5678);
      chk("enter_flag_off", 32'(res.redirflag), 32'd0);
      chk("enter_pc_held", res.redirpc, 32'h100);
      rd_chk("enter_mcause", 12'h342, 32'd2);
      rd_chk("enter_mtval", 12'h343, 32'hDEAD_BEEF);
      rd_chk("enter_mstatus", 12'h300, 32'h1880);

      // Return through a rewritten mepc
      csr_op(RW, 12'h341, 32'h2003, 0);
      tick();
      clear_in();
      trap(TRAP_RETURN, 0, 0, 0);
      tick();
      clear_in();
      #1 chk("ret_redirflag", 32'(res.redirflag), 32'd1);
      chk("ret_redirpc", res.redirpc, 32'h2000);
      tick();
      rd_chk("ret_mstatus", 12'h300, 32'h1888);
      rd_chk("ret_mepc", 12'h341, 32'h2000);

      // Back-to-back ENTER: second one lands in REDIRECT and is squashed
      trap(TRAP_ENTER, 32'd5, 32'h40, 0);
      tick();
      trap(TRAP_ENTER, 32'd7, 32'h80, 0);
      #1 chk("b2b_pulse", 32'(res.redirflag), 32'd1);
      tick();
      clear_in();
      #1 chk("b2b_single_pulse", 32'(res.redirflag), 32'd0);
      rd_chk("b2b_mcause", 12'h342, 32'd5);

      // RETURN racing an mepc write uses the old mepc
      trap(TRAP_RETURN, 0, 0, 0);
      csr_op(RW, 12'h341, 32'h3000, 0);
      tick();
      clear_in();
      #1 chk("ret_race_redirpc", res.redirpc, 32'h40);
      tick();
      rd_chk("ret_race_mepc", 12'h341, 32'h40);

      // ENTER racing an mscratch write drops the write
      csr_op(RW, 12'h340, 32'h11, 0);
      tick();
      clear_in();
      trap(TRAP_ENTER, 32'd3, 32'h100, 0);
      csr_op(RW, 12'h340, 32'h22, 0);
      #1 chk("race_rdata", rdata, 32'h11);
      tick();
      clear_in();
      tick();
      rd_chk("race_mscratch", 12'h340, 32'h11);

      // mcycle carry from a written low half, then full 64-bit wrap
      csr_op(RW, 12'hB00, 32'hFFFF_FFFF, 0);
      tick();
      csr_op(RW, 12'hB80, 32'h0, 0);
      tick();
      clear_in();
      rd_chk("cyc_lo_held", 12'hB00, 32'hFFFF_FFFF);
      rd_chk("cyc_carry_hi", 12'hB80, 32'd1);
      rd_chk("cyc_carry_lo", 12'hB00, 32'd1);
      csr_op(RW, 12'hB80, 32'hFFFF_FFFF, 0);
      tick();
      csr_op(RW, 12'hB00, 32'hFFFF_FFFF, 0);
      tick();
      clear_in();
      rd_chk("cyc_max", 12'hB00, 32'hFFFF_FFFF);
      rd_chk("cyc_wrap_hi", 12'hB80, 32'd0);

      // Reset coinciding with a trap request: no redirect follows
      trap(TRAP_ENTER, 32'd9, 32'h500, 0);
      start = 0;
      tick();
      start = 1;
      clear_in();
      #1 chk("rst_abort_flag", 32'(res.redirflag), 32'd0);
      tick();
      #1 chk("rst_abort_flag2", 32'(res.redirflag), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [11:0] alist[13];
         logic [2:0]  flist[6];
         alist = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
                   12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF14, 12'h7C0};
         flist = '{RW, RS, RC, 3'b101, 3'b110, 3'b111};
         start       = ($urandom_range(0, 199) != 0);
         req.valid   = ($urandom_range(0, 3) == 0);
         req.mode    = trap_mode_e'($urandom_range(0, 1));
         req.cause   = $urandom;
         req.pc      = $urandom;
         req.tval    = $urandom;
         retire      = $urandom_range(0, 1) == 1;
         csr_valid   = $urandom_range(0, 1) == 1;
         f3          = flist[$urandom_range(0, 5)];
         addr        = alist[$urandom_range(0, 12)];
         wd          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         sz          = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
